// File: rtl/aes_pkg.sv
// Shared AES-128 encryption definitions: FSM state type, S-box table and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // One state column, byte for row 0 in the top bits.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    endfunction

endpackage

// File: rtl/shift_rows.sv
// AES ShiftRows: row r of the column-major state rotates left by r byte positions.
module shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    always_comb begin
        dout = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                dout[127 - 8 * (4 * c + r) -: 8] = din[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
    end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES encryption core: one round per cycle, round keys supplied externally by index.
module aes_enc_core
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    localparam logic [3:0] NrCnt = 4'(NR);

    aes_state_e   fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;

    logic [127:0] sub_out;
    logic [127:0] shift_out;
    logic [127:0] mix_out;
    logic [127:0] round_out;

    always_comb begin
        sub_out = '0;
        for (int i = 0; i < 16; i++) begin
            sub_out[127 - 8 * i -: 8] = SBOX[data_q[127 - 8 * i -: 8]];
        end
    end

    shift_rows u_shift_rows (
        .din  (sub_out),
        .dout (shift_out)
    );

    always_comb begin
        mix_out = '0;
        for (int c = 0; c < 4; c++) begin
            mix_out[127 - 32 * c -: 32] = mix_column(shift_out[127 - 32 * c -: 32]);
        end
    end

    // Final round skips MixColumns.
    assign round_out = ((cnt_q == NrCnt) ? shift_out : mix_out) ^ rk;

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'd0;
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d = plaintext ^ rk;
                    cnt_d  = 4'd1;
                    fsm_d  = StRound;
                end
            end
            StRound: begin
                rk_idx = cnt_q;
                data_d = round_out;
                if (cnt_q == NrCnt) begin
                    fsm_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d = 4'd0;
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    assign busy       = (fsm_q != StIdle);
    assign ciphertext = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= StIdle;
            cnt_q  <= 4'd0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule
